// File: rtl/stream_rv_core_if.sv
// ----------------------------------------------------------------------------
// stream_rv_core_if
// Instruction stream handshake between an instruction feeder and the core.
//   instr_valid : feeder -> core, instr holds a valid instruction
//   instr       : feeder -> core, 32-bit RV32 instruction word
//   instr_ready : core -> feeder, core accepts instr this cycle
// Modports: master = feeder side, slave = core side.
// ----------------------------------------------------------------------------
interface stream_rv_core_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/stream_rv_core.sv
// ----------------------------------------------------------------------------
// stream_rv_core
// Two-stage (D: decode/execute, M: memory/writeback) RV32I-subset core fed by
// an external instruction stream. Supports ADDI, ADD/SUB, LW, SW, BEQ/BNE;
// anything else retires as a NOP and sets the sticky illegal flag.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   s_instr         instruction stream handshake (slave modport)
//   pc_out          PC of the instruction currently in D
//   redirect_valid  taken branch in D this cycle
//   redirect_pc     branch target, valid while redirect_valid
//   wb_valid/wb_rd  one-cycle pulse and destination of a retiring reg write
//   Final_Out       last value written to a register (holds)
//   retire_count    instructions retired, wraps
//   illegal         sticky: an unsupported opcode was accepted
// ----------------------------------------------------------------------------
module stream_rv_core #(
  parameter int              XLEN       = 32,
  parameter int              NREGS      = 32,
  parameter int              DMEM_WORDS = 64,
  parameter logic [XLEN-1:0] PC_RESET   = '0,
  parameter int              CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  stream_rv_core_if.slave   s_instr,
  output logic [XLEN-1:0]   pc_out,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   Final_Out,
  output logic [CNT_W-1:0]  retire_count,
  output logic              illegal
);
  localparam int AW = $clog2(DMEM_WORDS);
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  // True when the instruction word is one of the supported operations.
  function automatic logic f_legal(input logic [31:0] ins);
    logic ok;
    ok = 1'b0;
    case (ins[6:0])
      OP_IMM:            ok = (ins[14:12] == 3'b000);
      OP_REG:            ok = (ins[14:12] == 3'b000);
      OP_LOAD, OP_STORE: ok = 1'b1;
      OP_BR:             ok = (ins[14:13] == 2'b00);
      default:           ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Register index is writable/readable (x0 and indices >= NREGS are not).
  function automatic logic f_reg_ok(input logic [4:0] idx);
    return (idx != 5'd0) && (int'({27'd0, idx}) < NREGS);
  endfunction

  logic [XLEN-1:0] r_pc, r_d_pc, r_m_alu, r_m_sdata, r_final;
  logic [31:0]     r_d_instr;
  logic            r_d_valid, r_m_valid, r_m_wreg, r_m_load, r_m_store;
  logic            r_wb_valid, r_illegal;
  logic [4:0]      r_m_rd, r_wb_rd;
  logic [CNT_W-1:0] r_retire;
  logic [XLEN-1:0] r_regs [NREGS];
  logic [XLEN-1:0] r_dmem [DMEM_WORDS];

  logic            w_accept, w_m_we, w_d_legal, w_redirect;
  logic            w_wreg, w_load, w_store, w_taken;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic [6:0]      w_op;
  logic [XLEN-1:0] w_m_res, w_rs1_v, w_rs2_v, w_res, w_imm_i, w_imm_s, w_imm_b, w_target;

  assign w_accept = s_instr.instr_valid && s_instr.instr_ready;

  // M stage result: load data is read asynchronously, low address bits ignored.
  assign w_m_res = r_m_load ? r_dmem[r_m_alu[AW+1:2]] : r_m_alu;
  assign w_m_we  = r_m_valid && r_m_wreg && f_reg_ok(r_m_rd);

  assign w_op      = r_d_instr[6:0];
  assign w_rd      = r_d_instr[11:7];
  assign w_rs1     = r_d_instr[19:15];
  assign w_rs2     = r_d_instr[24:20];
  assign w_d_legal = f_legal(r_d_instr);
  assign w_imm_i   = {{(XLEN-12){r_d_instr[31]}}, r_d_instr[31:20]};
  assign w_imm_s   = {{(XLEN-12){r_d_instr[31]}}, r_d_instr[31:25], r_d_instr[11:7]};
  assign w_imm_b   = {{(XLEN-13){r_d_instr[31]}}, r_d_instr[31], r_d_instr[7],
                      r_d_instr[30:25], r_d_instr[11:8], 1'b0};

  // Operands forward from M when it writes the same register; this also
  // gives write-first behaviour for the regfile write on the same edge.
  assign w_rs1_v = !f_reg_ok(w_rs1) ? '0 :
                   (w_m_we && (r_m_rd == w_rs1)) ? w_m_res : r_regs[w_rs1];
  assign w_rs2_v = !f_reg_ok(w_rs2) ? '0 :
                   (w_m_we && (r_m_rd == w_rs2)) ? w_m_res : r_regs[w_rs2];

  // D stage execute: ALU result, memory address or branch compare.
  always_comb begin
    w_wreg  = 1'b0;
    w_load  = 1'b0;
    w_store = 1'b0;
    w_taken = 1'b0;
    w_res   = '0;
    case (w_d_legal ? w_op : 7'd0)
      OP_IMM: begin
        w_wreg = 1'b1;
        w_res  = w_rs1_v + w_imm_i;
      end
      OP_REG: begin
        w_wreg = 1'b1;
        w_res  = r_d_instr[30] ? (w_rs1_v - w_rs2_v) : (w_rs1_v + w_rs2_v);
      end
      OP_LOAD: begin
        w_wreg = 1'b1;
        w_load = 1'b1;
        w_res  = w_rs1_v + w_imm_i;
      end
      OP_STORE: begin
        w_store = 1'b1;
        w_res   = w_rs1_v + w_imm_s;
      end
      OP_BR: begin
        w_taken = r_d_instr[12] ? (w_rs1_v != w_rs2_v) : (w_rs1_v == w_rs2_v);
      end
      default: begin
        w_res = '0;
      end
    endcase
  end

  assign w_redirect          = r_d_valid && w_taken;
  assign w_target            = r_d_pc + w_imm_b;
  assign s_instr.instr_ready = !w_redirect;

  // Pipeline control: PC, D stage and M stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= PC_RESET;
      r_d_valid <= 1'b0;
      r_d_instr <= 32'd0;
      r_d_pc    <= '0;
      r_m_valid <= 1'b0;
      r_m_wreg  <= 1'b0;
      r_m_load  <= 1'b0;
      r_m_store <= 1'b0;
      r_m_rd    <= 5'd0;
      r_m_alu   <= '0;
      r_m_sdata <= '0;
    end else begin
      r_m_valid <= r_d_valid;
      r_m_wreg  <= r_d_valid && w_wreg;
      r_m_load  <= r_d_valid && w_load;
      r_m_store <= r_d_valid && w_store;
      r_m_rd    <= w_rd;
      r_m_alu   <= w_res;
      r_m_sdata <= w_rs2_v;
      r_d_valid <= w_accept;
      if (w_accept) begin
        r_d_instr <= s_instr.instr;
        r_d_pc    <= r_pc;
        r_pc      <= r_pc + PC_STEP;
      end else if (w_redirect) begin
        // A taken branch never coincides with an accept (ready is low).
        r_pc <= w_target;
      end
    end
  end

  // Architectural state: register file and data memory written from M.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      for (int j = 0; j < DMEM_WORDS; j++) r_dmem[j] <= '0;
    end else begin
      if (w_m_we) r_regs[r_m_rd] <= w_m_res;
      if (r_m_valid && r_m_store) r_dmem[r_m_alu[AW+1:2]] <= r_m_sdata;
    end
  end

  // Observation outputs: writeback pulse, last written value, retire count, illegal.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_final    <= '0;
      r_retire   <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_wb_valid <= w_m_we;
      if (w_m_we) begin
        r_wb_rd <= r_m_rd;
        r_final <= w_m_res;
      end
      if (r_m_valid) r_retire <= r_retire + CNT_W'(32'd1);
      if (w_accept && !f_legal(s_instr.instr)) r_illegal <= 1'b1;
    end
  end

  assign pc_out         = r_d_pc;
  assign redirect_valid = w_redirect;
  assign redirect_pc    = w_target;
  assign wb_valid       = r_wb_valid;
  assign wb_rd          = r_wb_rd;
  assign Final_Out      = r_final;
  assign retire_count   = r_retire;
  assign illegal        = r_illegal;
endmodule

// File: tb/tb_stream_rv_core.sv
// ----------------------------------------------------------------------------
// tb_stream_rv_core
// Directed and randomized stimulus for stream_rv_core. An ISA-level model
// executes each instruction when it is accepted; a two-entry delay line turns
// that into the cycle at which its writeback becomes visible. A second core
// with CNT_W=4 shares the stimulus to exercise the retire counter wrap.
// ----------------------------------------------------------------------------
module tb_stream_rv_core;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stream_rv_core_if u_if ();
  stream_rv_core_if u_if_s ();
  assign u_if_s.instr_valid = u_if.instr_valid;
  assign u_if_s.instr       = u_if.instr;

  logic [31:0] pc_out, redirect_pc, Final_Out;
  logic        redirect_valid, wb_valid, illegal;
  logic [4:0]  wb_rd;
  logic [15:0] retire_count;
  logic [31:0] s_pc_out, s_redirect_pc, s_final;
  logic        s_redirect_valid, s_wb_valid, s_illegal;
  logic [4:0]  s_wb_rd;
  logic [3:0]  s_retire_count;

  stream_rv_core dut (
    .clk(clk), .reset(reset), .s_instr(u_if.slave),
    .pc_out(pc_out), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .Final_Out(Final_Out),
    .retire_count(retire_count), .illegal(illegal)
  );

  stream_rv_core #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .s_instr(u_if_s.slave),
    .pc_out(s_pc_out), .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
    .wb_valid(s_wb_valid), .wb_rd(s_wb_rd), .Final_Out(s_final),
    .retire_count(s_retire_count), .illegal(s_illegal)
  );

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- ISA-level reference model ----------------
  typedef struct {bit v; bit wr; logic [4:0] rd; logic [31:0] val;} ev_t;
  logic [31:0] m_regs [32];
  logic [31:0] m_mem [64];
  logic [31:0] m_pc, m_dpc, m_dtgt;
  bit          m_dv, m_dtaken;
  ev_t         p0, p1;
  bit          e_ready, e_wbv, e_illegal;
  logic [4:0]  e_wbrd;
  logic [31:0] e_final;
  logic [15:0] e_cnt;

  logic [31:0] ins, a, b, val, addr, immi, imms, immb;
  logic [4:0]  rd;
  bit          wr, ill, tk;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      for (int i = 0; i < 64; i++) m_mem[i] = 32'd0;
      m_pc = 32'd0; m_dpc = 32'd0; m_dtgt = 32'd0; m_dv = 1'b0; m_dtaken = 1'b0;
      p0 = '{1'b0, 1'b0, 5'd0, 32'd0}; p1 = p0;
      e_ready = 1'b1; e_wbv = 1'b0; e_illegal = 1'b0; e_wbrd = 5'd0;
      e_final = 32'd0; e_cnt = 16'd0;
    end else begin
      e_wbv = 1'b0;
      if (p1.v) begin
        e_cnt = e_cnt + 16'd1;
        if (p1.wr) begin e_wbv = 1'b1; e_wbrd = p1.rd; e_final = p1.val; end
      end
      p1 = p0;
      p0 = '{1'b0, 1'b0, 5'd0, 32'd0};
      m_dv = 1'b0; m_dtaken = 1'b0;
      if (u_if.instr_valid && e_ready) begin
        ins  = u_if.instr;
        rd   = ins[11:7];
        a    = m_regs[ins[19:15]];
        b    = m_regs[ins[24:20]];
        immi = {{20{ins[31]}}, ins[31:20]};
        imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        wr = 1'b0; ill = 1'b0; tk = 1'b0; val = 32'd0;
        case (ins[6:0])
          7'h13: if (ins[14:12] == 3'd0) begin wr = 1'b1; val = a + immi; end else ill = 1'b1;
          7'h33: if (ins[14:12] == 3'd0) begin wr = 1'b1; val = ins[30] ? a - b : a + b; end
                 else ill = 1'b1;
          7'h03: begin addr = a + immi; wr = 1'b1; val = m_mem[addr[7:2]]; end
          7'h23: begin addr = a + imms; m_mem[addr[7:2]] = b; end
          7'h63: if (ins[14:12] == 3'd0) tk = (a == b);
                 else if (ins[14:12] == 3'd1) tk = (a != b);
                 else ill = 1'b1;
          default: ill = 1'b1;
        endcase
        if (ill) e_illegal = 1'b1;
        p0 = '{1'b1, wr && (rd != 5'd0), rd, val};
        if (wr && rd != 5'd0) m_regs[rd] = val;
        m_dv = 1'b1; m_dpc = m_pc; m_dtaken = tk; m_dtgt = m_pc + immb;
        m_pc = tk ? m_dtgt : m_pc + 32'd4;
      end
      e_ready = !(m_dv && m_dtaken);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (run) begin
      chk("instr_ready", 32'(u_if.instr_ready), 32'(e_ready));
      chk("redirect_valid", 32'(redirect_valid), 32'(m_dv && m_dtaken));
      if (m_dv && m_dtaken) chk("redirect_pc", redirect_pc, m_dtgt);
      if (m_dv) chk("pc_out", pc_out, m_dpc);
      chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
      if (e_wbv) chk("wb_rd", 32'(wb_rd), 32'(e_wbrd));
      chk("Final_Out", Final_Out, e_final);
      chk("retire_count", 32'(retire_count), 32'(e_cnt));
      chk("illegal", 32'(illegal), 32'(e_illegal));
      chk("retire_count_w4", 32'(s_retire_count), 32'(e_cnt[3:0]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit v, input logic [31:0] w);
    @(negedge clk);
    u_if.instr_valid = v;
    u_if.instr       = w;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; u_if.instr_valid = 1'b0; u_if.instr = 32'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(u_if.instr_ready), 32'd1);
    chk({tag, "_final"}, Final_Out, 32'd0);
    chk({tag, "_cnt"}, 32'(retire_count), 32'd0);
    chk({tag, "_ill"}, 32'(illegal), 32'd0);
    chk({tag, "_wbv"}, 32'(wb_valid), 32'd0);
    chk({tag, "_pc"}, pc_out, 32'd0);
    chk({tag, "_redir"}, 32'(redirect_valid), 32'd0);
  endtask

  logic [31:0] rnd, rw;
  logic [4:0]  r_d, r_s1, r_s2;

  initial begin
    reset = 1'b1; u_if.instr_valid = 1'b0; u_if.instr = 32'd0;
    do_reset();
    run = 1'b1;
    chk_all_zero("reset");

    // addi x1,x0,4: writeback visible two edges after accept
    cyc(1'b1, 32'h00400093);
    cyc(1'b0, 32'd0); chk("addi_e0_wbv", 32'(wb_valid), 32'd0);
    cyc(1'b0, 32'd0); chk("addi_e1_wbv", 32'(wb_valid), 32'd0);
    cyc(1'b0, 32'd0);
    chk("addi_wbv", 32'(wb_valid), 32'd1);
    chk("addi_rd", 32'(wb_rd), 32'd1);
    chk("addi_final", Final_Out, 32'd4);

    // addi x2,x0,8 ; add x3,x1,x2 back-to-back (forwarding)
    cyc(1'b1, 32'h00800113);
    cyc(1'b1, 32'h002081B3);
    repeat (3) cyc(1'b0, 32'd0);
    chk("add_final", Final_Out, 32'd12);
    chk("add_rd", 32'(wb_rd), 32'd3);

    // sw x1,0(x0) ; sw x2,4(x0) ; lw x4,0(x0)
    cyc(1'b1, 32'h00102023);
    cyc(1'b1, 32'h00202223);
    cyc(1'b1, 32'h00002203);
    repeat (3) cyc(1'b0, 32'd0);
    chk("lw4_final", Final_Out, 32'd4);
    chk("lw4_rd", 32'(wb_rd), 32'd4);

    // beq x2,x2,+1032 at PC 24 -> redirect to 0x420, then lw x5,4(x0)
    cyc(1'b1, 32'h40210463);
    cyc(1'b1, 32'h00402283);
    chk("beq_redir_v", 32'(redirect_valid), 32'd1);
    chk("beq_redir_pc", redirect_pc, 32'h420);
    chk("beq_ready", 32'(u_if.instr_ready), 32'd0);
    chk("beq_pc", pc_out, 32'd24);
    cyc(1'b1, 32'h00402283);
    cyc(1'b0, 32'd0);
    chk("target_pc", pc_out, 32'h420);
    cyc(1'b0, 32'd0);
    cyc(1'b0, 32'd0);
    chk("lw5_final", Final_Out, 32'd8);
    chk("lw5_rd", 32'(wb_rd), 32'd5);

    // unsupported opcode: sticky illegal, retires without wb pulse
    cyc(1'b1, 32'h0000007F);
    cyc(1'b0, 32'd0); chk("ill_flag", 32'(illegal), 32'd1);
    cyc(1'b0, 32'd0);
    cyc(1'b0, 32'd0);
    chk("ill_cnt", 32'(retire_count), 32'd9);
    chk("ill_wbv", 32'(wb_valid), 32'd0);
    cyc(1'b0, 32'd0);
    cyc(1'b1, 32'h00100313);
    cyc(1'b0, 32'd0);
    chk("bubble_pc", pc_out, 32'h428);
    repeat (3) cyc(1'b0, 32'd0);
    chk("ill_sticky", 32'(illegal), 32'd1);

    // reset while add x3,x1,x2 is in M
    cyc(1'b1, 32'h002081B3);
    cyc(1'b0, 32'd0);
    @(negedge clk);
    reset = 1'b1; u_if.instr_valid = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    reset = 1'b0;

    // 16 retires: the CNT_W=4 instance wraps to 0
    repeat (16) cyc(1'b1, 32'h00108093);
    repeat (3) cyc(1'b0, 32'd0);
    chk("wrap_cnt16", 32'(retire_count), 32'd16);
    chk("wrap_cnt4", 32'(s_retire_count), 32'd0);
    chk("wrap_final", Final_Out, 32'd16);

    // randomized instruction stream
    for (int i = 0; i < 600; i++) begin
      rnd  = $urandom;
      r_d  = 5'($urandom_range(0, 7));
      r_s1 = 5'($urandom_range(0, 7));
      r_s2 = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0, 1, 2: rw = {rnd[11:0], r_s1, 3'b000, r_d, 7'h13};
        3, 4:    rw = {1'b0, rnd[0], 5'd0, r_s2, r_s1, 3'b000, r_d, 7'h33};
        5:       rw = {rnd[11:0], r_s1, 3'b010, r_d, 7'h03};
        6:       rw = {rnd[11:5], r_s2, r_s1, 3'b010, rnd[4:0], 7'h23};
        7:       rw = {rnd[11:5], r_s2, r_s1, 2'b00, rnd[12], rnd[4:0], 7'h63};
        8:       rw = {rnd[24:0], 7'h7F};
        default: rw = {7'd0, rnd[4:0], 5'd0, 3'b000, r_d, 7'h13};
      endcase
      cyc($urandom_range(0, 9) < 8, rw);
      reset = (i == 300);
    end
    reset = 1'b0;
    repeat (4) cyc(1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
